pe_result_pack: RTL

PE_RESULT_PACK -- requirements
Module: pe_result_pack

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_result_pack_if.sv | 25 ++
 rtl/vec_fifo.sv | 54 +++++
 rtl/pe_result_pack.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants, FSM state encoding and beat helpers for the PE result packer.
package pe_pkg;

    localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
    localparam int unsigned BEATS_PER_VEC = 4;
    localparam int unsigned LANES         = 8;
    localparam int unsigned VEC_W         = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Beat k of a vector carries lanes 2k+1 (upper half) and 2k (lower half).
    function automatic logic [31:0] beat_sel(input logic [VEC_W-1:0] vec, input logic [1:0] idx);
        return vec[{idx, 5'd0} +: 32];
    endfunction

    function automatic logic [31:0] make_hdr(input logic [7:0] seq, input int unsigned frame_len);
        return {HDR_MAGIC, seq, 16'(frame_len * BEATS_PER_VEC)};
    endfunction

endpackage

// File: rtl/pe_result_pack_if.sv
// PE lane input and packet output bundle; master drives lanes and tx_rdy, slave is the packer.
interface pe_result_pack_if;
    import pe_pkg::*;

    logic [LANES-1:0][15:0] pe_data;
    logic                   pe_vld;
    logic                   pe_rdy;
    logic                   ovf_err;
    logic                   tx_sop;
    logic                   tx_eop;
    logic                   tx_vld;
    logic [31:0]            tx_data;
    logic                   tx_rdy;

    modport master (
        output pe_data, pe_vld, tx_rdy,
        input  pe_rdy, ovf_err, tx_sop, tx_eop, tx_vld, tx_data
    );

    modport slave (
        input  pe_data, pe_vld, tx_rdy,
        output pe_rdy, ovf_err, tx_sop, tx_eop, tx_vld, tx_data
    );

endinterface

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO with registered occupancy count and a head+1 peek port.
module vec_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [WIDTH-1:0]         rd_data_nxt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign full        = (count == (AW + 1)'(DEPTH));
    assign empty       = (count == '0);
    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;
    assign rd_ptr_nxt  = rd_ptr + AW'(1);
    assign rd_data     = mem[rd_ptr];
    assign rd_data_nxt = mem[rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pe_result_pack.sv
// Packs 8-lane PE result vectors into framed 32-bit packets: header beat plus FRAME_LEN*4 payload beats.
module pe_result_pack
    import pe_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pe_data_0,
    input  logic [15:0] pe_data_1,
    input  logic [15:0] pe_data_2,
    input  logic [15:0] pe_data_3,
    input  logic [15:0] pe_data_4,
    input  logic [15:0] pe_data_5,
    input  logic [15:0] pe_data_6,
    input  logic [15:0] pe_data_7,
    input  logic        pe_vld,
    output logic        pe_rdy,
    output logic        ovf_err,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_vld,
    output logic [31:0] tx_data,
    input  logic        tx_rdy
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [VEC_W-1:0] wr_vec;
    logic [VEC_W-1:0] rd_vec;
    logic [VEC_W-1:0] rd_vec_nxt;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             rdy_en;
    logic             push;
    logic             pop;

    state_t           state;
    logic [7:0]       seq;
    logic [1:0]       beat_cnt;
    logic [3:0]       vec_cnt;
    logic             tx_xfer;
    logic             last_vec;
    logic             has_next;

    assign wr_vec   = {pe_data_7, pe_data_6, pe_data_5, pe_data_4,
                       pe_data_3, pe_data_2, pe_data_1, pe_data_0};
    assign pe_rdy   = rdy_en & ~full;
    assign push     = pe_vld & pe_rdy;
    assign tx_xfer  = tx_vld & tx_rdy;
    assign last_vec = (vec_cnt == 4'(FRAME_LEN - 1));
    assign has_next = (count > CW'(1));
    assign pop      = (state == PAYLOAD) && tx_xfer && (beat_cnt == 2'd3);

    vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .wr_data     (wr_vec),
        .rd_data     (rd_vec),
        .rd_data_nxt (rd_vec_nxt),
        .full        (full),
        .empty       (empty),
        .count       (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            seq      <= '0;
            beat_cnt <= '0;
            vec_cnt  <= '0;
            tx_vld   <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            tx_data  <= '0;
            rdy_en   <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (pe_vld && !pe_rdy) ovf_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data <= make_hdr(seq, FRAME_LEN);
                        tx_sop  <= 1'b1;
                        tx_eop  <= 1'b0;
                        tx_vld  <= 1'b1;
                        state   <= HDR;
                    end else begin
                        tx_vld  <= 1'b0;
                    end
                end

                HDR: begin
                    if (tx_rdy) begin
                        state    <= PAYLOAD;
                        vec_cnt  <= '0;
                        beat_cnt <= '0;
                        tx_sop   <= 1'b0;
                        tx_eop   <= 1'b0;
                        tx_data  <= beat_sel(rd_vec, 2'd0);
                        tx_vld   <= ~empty;
                    end
                end

                PAYLOAD: begin
                    if (tx_xfer) begin
                        if (beat_cnt == 2'd3) begin
                            // The head vector is popped this edge, so the next one is read via the peek port.
                            if (last_vec) begin
                                seq      <= seq + 8'd1;
                                vec_cnt  <= '0;
                                beat_cnt <= '0;
                                tx_eop   <= 1'b0;
                                // Loading the next header here keeps packets back-to-back.
                                if (has_next) begin
                                    tx_data <= make_hdr(seq + 8'd1, FRAME_LEN);
                                    tx_sop  <= 1'b1;
                                    tx_vld  <= 1'b1;
                                    state   <= HDR;
                                end else begin
                                    tx_vld  <= 1'b0;
                                    state   <= IDLE;
                                end
                            end else begin
                                vec_cnt  <= vec_cnt + 4'd1;
                                beat_cnt <= '0;
                                tx_eop   <= 1'b0;
                                tx_data  <= beat_sel(rd_vec_nxt, 2'd0);
                                tx_vld   <= has_next;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                            tx_data  <= beat_sel(rd_vec, beat_cnt + 2'd1);
                            tx_eop   <= last_vec && (beat_cnt == 2'd2);
                        end
                    end else if (!tx_vld && !empty) begin
                        tx_data <= beat_sel(rd_vec, beat_cnt);
                        tx_vld  <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
